// File: rtl/pixel_row_streamer.sv
// pixel_row_streamer
// Streams a contiguous, optionally wrapping range of image rows, one row per
// accepted beat, on a registered valid/ready output. The image is not
// captured; In must stay stable from Start until Done.
// Build option: define PIXEL_ROW_ZERO_PAD_EN to make beats whose row index is
// >= NUM_ROWS carry all-zero data (border padding); otherwise they carry row 0.
module pixel_row_streamer #(
  parameter int PIXEL_BITS = 10,
  parameter int ROW_PIXELS = 28,
  parameter int NUM_ROWS   = 28,
  parameter int SEL_BIT    = 5
) (
  input  logic                                    clk,
  input  logic                                    GlobalReset,
  input  logic [NUM_ROWS*ROW_PIXELS*PIXEL_BITS-1:0] In,
  input  logic                                    Start,
  input  logic [SEL_BIT-1:0]                      FirstRow,
  input  logic [SEL_BIT-1:0]                      LastRow,
  input  logic                                    Ready,
  output logic [ROW_PIXELS*PIXEL_BITS-1:0]        Out,
  output logic                                    OutValid,
  output logic [SEL_BIT-1:0]                      RowIdx,
  output logic                                    Busy,
  output logic                                    Done
);

  localparam int ROW_W = ROW_PIXELS * PIXEL_BITS;
  localparam int IMG_W = NUM_ROWS * ROW_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_BIT-1:0]   row_idx_q, row_idx_d;
  logic [SEL_BIT-1:0]   last_row_q, last_row_d;
  logic [ROW_W-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 xfer_s;
  logic                 at_last_s;
  logic [SEL_BIT-1:0]   next_idx_s;

  // Row selector; out-of-range indices fall back to zeros or row 0
  function automatic logic [ROW_W-1:0] select_row(input logic [SEL_BIT-1:0] idx,
                                                  input logic [IMG_W-1:0]   img);
    logic [ROW_W-1:0] r;
    if (int'(idx) < NUM_ROWS) begin
      r = img[int'(idx)*ROW_W +: ROW_W];
    end else begin
`ifdef PIXEL_ROW_ZERO_PAD_EN
      r = {ROW_W{1'b0}};
`else
      r = img[ROW_W-1:0];
`endif
    end
    return r;
  endfunction

  assign xfer_s     = out_valid_q & Ready;
  assign at_last_s  = (row_idx_q == last_row_q);
  assign next_idx_s = (row_idx_q == SEL_BIT'(NUM_ROWS - 1)) ? {SEL_BIT{1'b0}}
                                                            : row_idx_q + {{(SEL_BIT-1){1'b0}}, 1'b1};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q     <= ST_IDLE;
      row_idx_q   <= {SEL_BIT{1'b0}};
      last_row_q  <= {SEL_BIT{1'b0}};
      out_q       <= {ROW_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      last_row_q  <= last_row_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (xfer_s && at_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on Start, advance on accepted beats, hold on stall
  always_comb begin
    row_idx_d   = row_idx_q;
    last_row_d  = last_row_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          row_idx_d   = FirstRow;
          last_row_d  = LastRow;
          out_d       = select_row(FirstRow, In);
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_STREAM: begin
        if (xfer_s) begin
          if (at_last_s) begin
            out_valid_d = 1'b0;
          end else begin
            row_idx_d   = next_idx_s;
            out_d       = select_row(next_idx_s, In);
            out_valid_d = 1'b1;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      ST_DONE: out_valid_d = 1'b0;
      default: out_valid_d = 1'b0;
    endcase
  end

  // Status outputs, decoded from the next state so they come out of flops
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_STREAM: busy_d = 1'b1;
      ST_DONE:   done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign Out      = out_q;
  assign OutValid = out_valid_q;
  assign RowIdx   = row_idx_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_pixel_row_streamer.sv
// Self-checking bench for pixel_row_streamer: table of streams, hand-written
// reset sequences, and randomized streams against a row-sequence model.
module tb_pixel_row_streamer;

  localparam int PIXEL_BITS = 10;
  localparam int ROW_PIXELS = 28;
  localparam int NUM_ROWS   = 28;
  localparam int SEL_BIT    = 5;
  localparam int ROW_W      = ROW_PIXELS * PIXEL_BITS;
  localparam int IMG_W      = NUM_ROWS * ROW_W;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [IMG_W-1:0]   img;
  logic               start = 1'b0;
  logic [SEL_BIT-1:0] first_row = '0;
  logic [SEL_BIT-1:0] last_row = '0;
  logic               ready = 1'b0;
  logic [ROW_W-1:0]   out_w;
  logic               out_valid;
  logic [SEL_BIT-1:0] row_idx;
  logic               busy;
  logic               done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [SEL_BIT-1:0] first;
    logic [SEL_BIT-1:0] last;
    bit                 rnd_ready;
    int                 stall_idx;
    int                 stall_len;
    int                 restart_idx;
    int                 exp_beats;
  } vec_t;

  pixel_row_streamer #(
    .PIXEL_BITS(PIXEL_BITS), .ROW_PIXELS(ROW_PIXELS),
    .NUM_ROWS(NUM_ROWS), .SEL_BIT(SEL_BIT)
  ) dut (
    .clk(clk), .GlobalReset(rst), .In(img), .Start(start),
    .FirstRow(first_row), .LastRow(last_row), .Ready(ready),
    .Out(out_w), .OutValid(out_valid), .RowIdx(row_idx),
    .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] exp_row(input int idx);
    if (idx < NUM_ROWS) return img[idx*ROW_W +: ROW_W];
`ifdef PIXEL_ROW_ZERO_PAD_EN
    return '0;
`else
    return img[ROW_W-1:0];
`endif
  endfunction

  task automatic fill_image();
    for (int p = 0; p < NUM_ROWS * ROW_PIXELS; p++) img[p*PIXEL_BITS +: PIXEL_BITS] = PIXEL_BITS'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with DUT idle.
  task automatic run_stream(input vec_t v);
    int q[$];
    int idx;
    int beats = 0;
    int cyc = 0;
    int stall_left = v.stall_len;
    bit restarted = 1'b0;
    idx = int'(v.first);
    forever begin
      q.push_back(idx);
      if (idx == int'(v.last)) break;
      idx = (idx == NUM_ROWS - 1) ? 0 : idx + 1;
    end
    start = 1'b1; first_row = v.first; last_row = v.last; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (q.size() > 0 && cyc < 2000) begin
      cyc++;
      check("valid", ROW_W'(out_valid), ROW_W'(1));
      check("busy", ROW_W'(busy), ROW_W'(1));
      check("done_low", ROW_W'(done), ROW_W'(0));
      check("rowidx", ROW_W'(row_idx), ROW_W'(q[0]));
      check("out", out_w, exp_row(q[0]));
      start = 1'b0;
      if (v.restart_idx >= 0 && !restarted && int'(row_idx) == v.restart_idx) begin
        start = 1'b1; first_row = 5'd20; last_row = 5'd20; restarted = 1'b1;
      end
      if (v.stall_idx >= 0 && int'(row_idx) == v.stall_idx && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && ready) begin
        void'(q.pop_front());
        beats++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (q.size() > 0) check("timeout", ROW_W'(q.size()), ROW_W'(0));
    check("beats", ROW_W'(beats), ROW_W'(v.exp_beats));
    check("done_pulse", ROW_W'(done), ROW_W'(1));
    check("valid_after", ROW_W'(out_valid), ROW_W'(0));
    check("busy_after", ROW_W'(busy), ROW_W'(0));
    @(negedge clk);
    check("done_clear", ROW_W'(done), ROW_W'(0));
    check("busy_idle", ROW_W'(busy), ROW_W'(0));
    check("valid_idle", ROW_W'(out_valid), ROW_W'(0));
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int f, l;
    bit found;
    tbl[0] = '{5'd0,  5'd27, 1'b0, -1, 0, -1, 28};
    tbl[1] = '{5'd3,  5'd8,  1'b0,  5, 3, -1, 6};
    tbl[2] = '{5'd26, 5'd1,  1'b0, -1, 0, -1, 4};
    tbl[3] = '{5'd30, 5'd30, 1'b0, -1, 0, -1, 1};
    tbl[4] = '{5'd5,  5'd5,  1'b0, -1, 0, -1, 1};
    tbl[5] = '{5'd0,  5'd9,  1'b0, -1, 0,  4, 10};
    tbl[6] = '{5'd20, 5'd19, 1'b1, -1, 0, -1, 28};
    tbl[7] = '{5'd27, 5'd0,  1'b1, -1, 0, -1, 2};

    fill_image();

    // Reset held two cycles with Start high: nothing may come out
    @(negedge clk);
    rst = 1'b1; start = 1'b1; first_row = 5'd5; last_row = 5'd7; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_out", out_w, '0);
      check("rst_valid", ROW_W'(out_valid), ROW_W'(0));
      check("rst_idx", ROW_W'(row_idx), ROW_W'(0));
      check("rst_busy", ROW_W'(busy), ROW_W'(0));
      check("rst_done", ROW_W'(done), ROW_W'(0));
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_valid", ROW_W'(out_valid), ROW_W'(0));
    check("post_rst_busy", ROW_W'(busy), ROW_W'(0));

    // Table-driven streams
    for (int t = 0; t < 8; t++) run_stream(tbl[t]);

    // Mid-stream reset at RowIdx 10, then a single-row stream
    start = 1'b1; first_row = 5'd0; last_row = 5'd27; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (out_valid && row_idx == 5'd10) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_idx10", ROW_W'(row_idx), ROW_W'(10));
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid", ROW_W'(out_valid), ROW_W'(0));
    check("mrst_busy", ROW_W'(busy), ROW_W'(0));
    check("mrst_done", ROW_W'(done), ROW_W'(0));
    check("mrst_out", out_w, '0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_idle_valid", ROW_W'(out_valid), ROW_W'(0));
    rv = '{5'd2, 5'd2, 1'b0, -1, 0, -1, 1};
    run_stream(rv);

    // Randomized streams over fresh images with random backpressure
    for (int r = 0; r < 10; r++) begin
      fill_image();
      f = $urandom_range(0, NUM_ROWS - 1);
      l = $urandom_range(0, NUM_ROWS - 1);
      rv.first = SEL_BIT'(f);
      rv.last = SEL_BIT'(l);
      rv.rnd_ready = 1'b1;
      rv.stall_idx = -1;
      rv.stall_len = 0;
      rv.restart_idx = -1;
      rv.exp_beats = (l >= f) ? (l - f + 1) : (NUM_ROWS - f + l + 1);
      run_stream(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
